// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg: shared regfile widths, wait-counter width and arbiter state encoding
package wb_arbiter_pkg;
  localparam int REG_W = 5;
  localparam int DATA_W = 32;
  localparam int WAIT_W = 4;
  typedef enum logic [1:0] {IDLE, WAIT, FORCE} arb_state_e;
endpackage

// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: pipe WB-stage request, aux (mul/div) request/ready, stall, regfile write port and forced-stall count
interface wb_arbiter_if #(parameter int CNT_W = 16);
  import wb_arbiter_pkg::*;
  logic pipe_we;
  logic [REG_W-1:0] pipe_rd;
  logic [DATA_W-1:0] pipe_data;
  logic aux_valid;
  logic [REG_W-1:0] aux_rd;
  logic [DATA_W-1:0] aux_data;
  logic aux_ready;
  logic pipe_stall;
  logic rf_we;
  logic [REG_W-1:0] rf_rd;
  logic [DATA_W-1:0] rf_data;
  logic [CNT_W-1:0] stall_count;
  modport master (
    output pipe_we, pipe_rd, pipe_data, aux_valid, aux_rd, aux_data,
    input aux_ready, pipe_stall, rf_we, rf_rd, rf_data, stall_count
  );
  modport slave (
    input pipe_we, pipe_rd, pipe_data, aux_valid, aux_rd, aux_data,
    output aux_ready, pipe_stall, rf_we, rf_rd, rf_data, stall_count
  );
endinterface

// File: rtl/wb_arbiter.sv
// wb_arbiter: regfile write-port arbiter (clk, reset, bus.slave) -- pipe wins unless aux starves STARVE_LIMIT cycles, then one forced stall
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic reset,
  wb_arbiter_if.slave bus
);
  localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(STARVE_LIMIT);
  arb_state_e state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt, wait_inc;
  logic [CNT_W-1:0] stall_cnt;
  logic slot_free, pipe_grant, aux_grant, blocked, we_nxt, rf_we_q;
  logic [REG_W-1:0] rd_nxt, rf_rd_q;
  logic [DATA_W-1:0] data_nxt, rf_data_q;
  assign slot_free = !bus.pipe_we || bus.pipe_rd == '0 || state == FORCE;
  assign pipe_grant = !slot_free;
  assign aux_grant = !reset && bus.aux_valid && slot_free;
  assign blocked = bus.aux_valid && !slot_free;
  assign wait_inc = wait_cnt + 1'b1;
  assign bus.aux_ready = aux_grant;
  assign bus.pipe_stall = !reset && state == FORCE;
  assign bus.rf_we = rf_we_q;
  assign bus.rf_rd = rf_rd_q;
  assign bus.rf_data = rf_data_q;
  assign bus.stall_count = stall_cnt;
  always_comb begin
    state_nxt = blocked ? (wait_inc == LIMIT ? FORCE : WAIT) : IDLE;
    wait_nxt = blocked ? wait_inc : '0;
    rd_nxt = pipe_grant ? bus.pipe_rd : aux_grant ? bus.aux_rd : '0;
    data_nxt = pipe_grant ? bus.pipe_data : aux_grant ? bus.aux_data : '0;
    we_nxt = (pipe_grant || aux_grant) && rd_nxt != '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      wait_cnt <= '0;
      stall_cnt <= '0;
      rf_we_q <= 1'b0;
      rf_rd_q <= '0;
      rf_data_q <= '0;
    end else begin
      state <= state_nxt;
      wait_cnt <= wait_nxt;
      stall_cnt <= stall_cnt + CNT_W'(state == FORCE && !(&stall_cnt));
      rf_we_q <= we_nxt;
      rf_rd_q <= rd_nxt;
      rf_data_q <= data_nxt;
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed checks of grant, starvation stall, reset abandon and counter saturation
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;
  localparam int CW = 2;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  wb_arbiter_if #(.CNT_W(CW)) bus ();
  wb_arbiter #(.STARVE_LIMIT(4), .CNT_W(CW)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic pwe, input logic [4:0] prd, input logic [31:0] pd,
                       input logic av, input logic [4:0] ard, input logic [31:0] ad);
    bus.pipe_we = pwe;
    bus.pipe_rd = prd;
    bus.pipe_data = pd;
    bus.aux_valid = av;
    bus.aux_rd = ard;
    bus.aux_data = ad;
    #1;
  endtask
  task automatic chk_rf(input string tag, input logic we, input logic [4:0] rd, input logic [31:0] d);
    chk({tag, "_we"}, 32'(bus.rf_we), 32'(we));
    chk({tag, "_rd"}, 32'(bus.rf_rd), 32'(rd));
    chk({tag, "_data"}, bus.rf_data, d);
  endtask
  initial begin
    drive(1'b1, 5'd6, 32'h66, 1'b1, 5'd2, 32'h22);
    tick;
    tick;
    chk_rf("rst", 1'b0, 5'd0, 32'h0);
    chk("rst_ready", 32'(bus.aux_ready), 0);
    chk("rst_stall", 32'(bus.pipe_stall), 0);
    chk("rst_cnt", 32'(bus.stall_count), 0);
    reset = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick;
    drive(1'b1, 5'd5, 32'h11, 1'b0, 5'd0, 32'h0);
    chk("pipe_ready", 32'(bus.aux_ready), 0);
    tick;
    chk_rf("pipe", 1'b1, 5'd5, 32'h11);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'hAB);
    chk("aux_ready", 32'(bus.aux_ready), 1);
    tick;
    chk_rf("aux", 1'b1, 5'd7, 32'hAB);
    drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd9, 32'h99);
    for (int i = 0; i < 4; i++) begin
      chk("starve_ready", 32'(bus.aux_ready), 0);
      chk("starve_stall", 32'(bus.pipe_stall), 0);
      tick;
    end
    chk("force_stall", 32'(bus.pipe_stall), 1);
    chk("force_ready", 32'(bus.aux_ready), 1);
    chk_rf("force_pipe", 1'b1, 5'd3, 32'h33);
    tick;
    chk_rf("force_aux", 1'b1, 5'd9, 32'h99);
    chk("force_cnt", 32'(bus.stall_count), 1);
    chk("after_force_stall", 32'(bus.pipe_stall), 0);
    drive(1'b1, 5'd0, 32'h55, 1'b1, 5'd4, 32'h44);
    chk("rd0_ready", 32'(bus.aux_ready), 1);
    chk("rd0_stall", 32'(bus.pipe_stall), 0);
    tick;
    chk_rf("rd0", 1'b1, 5'd4, 32'h44);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h77);
    chk("auxr0_ready", 32'(bus.aux_ready), 1);
    tick;
    chk("auxr0_we", 32'(bus.rf_we), 0);
    drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd9, 32'h99);
    tick;
    tick;
    reset = 1'b1;
    tick;
    chk_rf("wrst", 1'b0, 5'd0, 32'h0);
    chk("wrst_ready", 32'(bus.aux_ready), 0);
    chk("wrst_stall", 32'(bus.pipe_stall), 0);
    chk("wrst_cnt", 32'(bus.stall_count), 0);
    reset = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick;
    chk("wrst_nowrite", 32'(bus.rf_we), 0);
    drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd9, 32'h99);
    tick;
    tick;
    drive(1'b1, 5'd3, 32'h33, 1'b0, 5'd9, 32'h99);
    tick;
    drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd9, 32'h99);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("drop_stall", 32'(bus.pipe_stall), 0);
    end
    tick;
    chk("drop_force", 32'(bus.pipe_stall), 1);
    tick;
    chk("sat_cnt1", 32'(bus.stall_count), 1);
    for (int k = 2; k <= 4; k++) begin
      for (int i = 0; i < 4; i++) tick;
      chk("sat_stall", 32'(bus.pipe_stall), 1);
      tick;
      chk("sat_cnt", 32'(bus.stall_count), (k > 3) ? 3 : k);
    end
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
